// File: rtl/demo_pkg.sv
// Shared types and helpers for the demo scene sequencer.
package demo_pkg;

   typedef enum logic [1:0] {
      FADE_IN  = 2'd0,
      PLAY     = 2'd1,
      FADE_OUT = 2'd2,
      SWITCH   = 2'd3
   } seq_state_t;

   // Full-brightness code for a fade register of the given width.
   function automatic int fade_max(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pad, with a registered rising-edge pulse.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end

   assign level = s2;

endmodule

// File: rtl/demo_sequencer.sv
// Scene scheduler: frame counting, fade envelope and skip/pause handling per scene.
module demo_sequencer
   import demo_pkg::*;
#(
   parameter int NUM_SCENES   = 8,
   parameter int SCENE_FRAMES = 256,
   parameter int FADE_BITS    = 4,
   parameter int FRAME_BITS   = 9,
   localparam int SCENE_W     = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_frame,
   input  logic [1:0]            advance,
   output logic [SCENE_W-1:0]    scene,
   output logic [FRAME_BITS-1:0] scene_frame,
   output logic [FADE_BITS-1:0]  fade,
   output logic                  scene_start,
   output logic                  paused
);

   localparam int                  FADE_MAX   = fade_max(FADE_BITS);
   localparam logic [FADE_BITS-1:0] FADE_FULL  = FADE_BITS'(FADE_MAX);
   localparam logic [FRAME_BITS-1:0] PLAY_END  = FRAME_BITS'(SCENE_FRAMES - FADE_MAX);
   localparam logic [SCENE_W-1:0]  SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

   logic [1:0] adv_lvl, adv_rise;
   logic       skip_edge, strobe, sync_unused;

   for (genvar i = 0; i < 2; i++) begin : g_sync
      sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (advance[i]),
         .level (adv_lvl[i]),
         .rise  (adv_rise[i])
      );
   end

   assign skip_edge   = adv_rise[0];
   assign paused      = adv_lvl[1];
   assign sync_unused = adv_lvl[0] ^ adv_rise[1];
   assign strobe      = new_frame & ~paused;

   seq_state_t              state, state_d;
   logic                    skip_pending, pend_d, start_d;
   logic [SCENE_W-1:0]      scene_d;
   logic [FRAME_BITS-1:0]   frame_d, frame_inc;
   logic [FADE_BITS-1:0]    fade_d, fade_inc, fade_dec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= FADE_IN;
         scene        <= '0;
         scene_frame  <= '0;
         fade         <= '0;
         skip_pending <= 1'b0;
         scene_start  <= 1'b0;
      end else begin
         state        <= state_d;
         scene        <= scene_d;
         scene_frame  <= frame_d;
         fade         <= fade_d;
         skip_pending <= pend_d;
         scene_start  <= start_d;
      end
   end

   always_comb begin
      state_d   = state;
      scene_d   = scene;
      frame_d   = scene_frame;
      fade_d    = fade;
      pend_d    = skip_pending;
      start_d   = 1'b0;
      frame_inc = scene_frame + 1'b1;
      fade_inc  = fade + 1'b1;
      fade_dec  = (fade == '0) ? '0 : fade - 1'b1;

      // Skip requests are only accepted while the scene is still visible.
      if (skip_edge && state != FADE_OUT && state != SWITCH)
         pend_d = 1'b1;

      case (state)
         FADE_IN: if (strobe) begin
            frame_d = frame_inc;
            if (skip_pending) begin
               state_d = FADE_OUT;
               pend_d  = 1'b0;
            end else begin
               fade_d = fade_inc;
               if (fade_inc == FADE_FULL) state_d = PLAY;
            end
         end
         PLAY: if (strobe) begin
            frame_d = frame_inc;
            if (skip_pending || frame_inc == PLAY_END) begin
               state_d = FADE_OUT;
               pend_d  = 1'b0;
            end
         end
         FADE_OUT: if (strobe) begin
            frame_d = frame_inc;
            fade_d  = fade_dec;
            if (fade_dec == '0) state_d = SWITCH;
         end
         SWITCH: begin
            scene_d = (scene == SCENE_LAST) ? '0 : scene + 1'b1;
            frame_d = '0;
            state_d = FADE_IN;
            start_d = 1'b1;
         end
         default: state_d = FADE_IN;
      endcase
   end

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer with 4 scenes of 64 frames and a 2-bit fade.
module tb_demo_sequencer;
   import demo_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       new_frame;
   logic [1:0] advance;
   logic [1:0] scene;
   logic [6:0] scene_frame;
   logic [1:0] fade;
   logic       scene_start;
   logic       paused;

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;

   demo_sequencer #(
      .NUM_SCENES   (4),
      .SCENE_FRAMES (64),
      .FADE_BITS    (2),
      .FRAME_BITS   (7)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .new_frame   (new_frame),
      .advance     (advance),
      .scene       (scene),
      .scene_frame (scene_frame),
      .fade        (fade),
      .scene_start (scene_start),
      .paused      (paused)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (scene_start === 1'b1) n_start++;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
   endtask

   // Pad pulse, then enough idle cycles for it to reach skip_pending.
   task automatic skip_pulse();
      advance[0] = 1'b1;
      repeat (2) tick();
      advance[0] = 1'b0;
      repeat (4) tick();
   endtask

   task automatic chk_out(input string tag, input int sc, input int fr, input int fd);
      chk({tag, ".scene"}, int'(scene), sc);
      chk({tag, ".frame"}, int'(scene_frame), fr);
      chk({tag, ".fade"},  int'(fade), fd);
   endtask

   initial begin
      reset     = 1'b1;
      new_frame = 1'b0;
      advance   = 2'b00;
      repeat (2) tick();
      chk_out("rst", 0, 0, 0);
      chk("rst.start", int'(scene_start), 0);
      chk("rst.paused", int'(paused), 0);
      reset = 1'b0;
      tick();

      // Fade in over three strobes
      for (int i = 1; i <= 3; i++) begin
         strobe();
         chk_out("fadein", 0, i, i);
      end
      chk("fadein.state", int'(dut.state), int'(PLAY));

      // Natural end of scene 0
      repeat (57) strobe();
      chk_out("play60", 0, 60, 3);
      strobe();
      chk_out("s61", 0, 61, 3);
      chk("s61.state", int'(dut.state), int'(FADE_OUT));
      for (int i = 2; i >= 0; i--) begin
         strobe();
         chk_out("fadeout", 0, 64 - i, i);
      end
      chk("pre_switch.start", int'(scene_start), 0);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      chk_out("switch", 1, 0, 0);
      chk("switch.start", int'(scene_start), 1);
      tick();
      chk("switch.start_drop", int'(scene_start), 0);
      chk_out("switch_hold", 1, 0, 0);

      // Skip at frame 10 in scene 1; a second skip during fade-out is ignored
      repeat (10) strobe();
      chk_out("pre_skip", 1, 10, 3);
      skip_pulse();
      chk_out("skip_wait", 1, 10, 3);
      strobe();
      chk_out("skip_hit", 1, 11, 3);
      chk("skip_hit.state", int'(dut.state), int'(FADE_OUT));
      skip_pulse();
      repeat (3) strobe();
      chk_out("skip_out", 1, 14, 0);
      tick();
      chk_out("skip_switch", 2, 0, 0);
      chk("skip_switch.start", int'(scene_start), 1);
      strobe();
      chk_out("no_ghost_skip", 2, 1, 1);
      repeat (2) strobe();
      chk_out("s2_play", 2, 3, 3);

      // Pause freezes counters but keeps a skip request
      advance[1] = 1'b1;
      repeat (3) tick();
      chk("paused.on", int'(paused), 1);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) advance[0] = 1'b1;
         if (i == 7) advance[0] = 1'b0;
         new_frame = 1'b1;
         tick();
         new_frame = 1'b0;
         tick();
      end
      chk_out("paused.frozen", 2, 3, 3);
      advance[1] = 1'b0;
      repeat (3) tick();
      chk("paused.off", int'(paused), 0);
      strobe();
      chk_out("unpause", 2, 4, 3);
      chk("unpause.state", int'(dut.state), int'(FADE_OUT));
      repeat (2) strobe();
      chk_out("mid_fadeout", 2, 6, 1);

      // Asynchronous reset between clock edges
      #3 reset = 1'b1;
      #1;
      chk_out("async_rst", 0, 0, 0);
      chk("async_rst.state", int'(dut.state), int'(FADE_IN));
      tick();
      reset = 1'b0;
      tick();

      // Four undisturbed scenes
      n_start = 0;
      for (int s = 0; s < 4; s++) begin
         repeat (64) strobe();
         chk("full.fade", int'(fade), 0);
         chk("full.scene_hold", int'(scene), s);
         tick();
         chk_out("full.next", (s + 1) % 4, 0, 0);
      end
      tick();
      chk("full.starts", n_start, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
